uart_cmd_decoder: RTL and testbench
===================================

Name: uart_cmd_decoder

Overview:
Downstream consumer of the 8-bit UART receiver. Assembles received bytes into a 2-byte command frame (command code, then address), validates both, and hands the frame to the command executor over a valid/ready handshake. Enforces an inter-byte timeout and reports framing errors as a one-cycle coded pulse. Runs on the receiver's 16x-oversample clock.

Parameters:
MAX_CMD, 8'h07, highest legal command code; codes above it are rejected.
NUM_ADDR, 32, legal addresses are 0..NUM_ADDR-1.
TIMEOUT_CYCLES, 1600, maximum clk cycles allowed between frame bytes (10 byte times at 16x).
CNT_W, 11, timeout counter width; must satisfy 2^CNT_W >= TIMEOUT_CYCLES.

Ports:
clk  in  1  clock, same 16x baud clock as the receiver.
rst_n  in  1  reset, asynchronous, active-low.
rx_data  in  8  byte from the receiver; valid only when rx_done=1.
rx_done  in  1  one-cycle pulse: rx_data holds a new byte.
rx_err  in  1  receiver line error; aborts the current frame.
cmd_valid  out  1  frame available.
cmd_ready  in  1  consumer accepts the frame.
cmd_code  out  8  command code; stable while cmd_valid=1.
cmd_addr  out  8  address; stable while cmd_valid=1.
busy  out  1  frame in progress or awaiting handshake.
err_valid  out  1  one-cycle error pulse.
err_code  out  3  1 BAD_CMD, 2 BAD_ADDR, 3 TIMEOUT, 4 RX_ERR, 5 OVERRUN, 6 BAD_CSUM; 0 when err_valid=0.

Behaviour:
- Reset (asynchronous, rst_n=0): state IDLE; cmd_valid, busy, err_valid = 0; cmd_code, cmd_addr, err_code = 0; timer = 0. Takes effect immediately, including mid-frame.
- All outputs are registered.
- IDLE: on rx_done, if rx_data <= MAX_CMD, latch rx_data into the code register, clear the timer and go to WAIT_ADDR. Otherwise pulse err_valid with BAD_CMD on the next cycle and stay in IDLE.
- WAIT_ADDR: the timer increments every cycle.
  - On rx_done with rx_data < NUM_ADDR: latch the address and go to HOLD (or WAIT_CSUM when enabled).
  - On rx_done with an out-of-range address: BAD_ADDR, go to IDLE.
  - If the timer reaches TIMEOUT_CYCLES-1 with no rx_done that cycle: TIMEOUT, go to IDLE.
  - If rx_done and expiry coincide, the byte wins.
- HOLD: cmd_valid=1 starting the cycle after the address byte's rx_done (latency 1). cmd_code and cmd_addr are held.
  - Transfer occurs on cmd_valid & cmd_ready; cmd_valid drops the next cycle and the state returns to IDLE.
  - rx_done while cmd_ready=0: byte dropped, OVERRUN pulsed, frame kept.
  - rx_done in the handshake cycle: byte is processed as a new command byte using IDLE rules.
- rx_err in any non-IDLE state: RX_ERR, go to IDLE, any pending frame discarded (cmd_valid drops).
  - rx_err in IDLE: ignored.
  - rx_err together with rx_done: rx_err wins and the byte is dropped.
- Only one error per cycle. Priority: RX_ERR > TIMEOUT > OVERRUN > BAD_CMD/BAD_ADDR/BAD_CSUM.
- busy = 1 in every state except IDLE.
- Timer saturates; it never wraps.

Optional Feature:
UART_CMD_CHECKSUM_EN:
- Defined: the frame is 3 bytes. After a valid address, the FSM waits in WAIT_CSUM under the same timeout rules.
  - Third byte equal to code ^ addr: go to HOLD.
  - Otherwise: BAD_CSUM, go to IDLE.
- Undefined: WAIT_CSUM and checksum logic are absent; the frame is 2 bytes and err_code 6 never occurs.

Decomposition:
- Package uart_cmd_pkg holds:
  - state encoding: IDLE, WAIT_ADDR, WAIT_CSUM, HOLD;
  - err_code constants ERR_NONE..ERR_BAD_CSUM;
  - legal command code constants shared with the executor.
- One sub-module, uart_cmd_timer: a clear/enable saturating counter with an expiry flag, parameterised by TIMEOUT_CYCLES and CNT_W.

Test Plan:
- Send 0x03 then 0x10 with cmd_ready=1 -> cmd_valid high exactly one cycle after the second rx_done, cmd_code=0x03, cmd_addr=0x10, no err_valid, busy returns to 0.
- Send 0x09 -> err_valid for one cycle with err_code=1, state stays IDLE; then 0x01, 0x02 -> frame delivered normally.
- Send 0x01, then nothing -> err_code=3 pulse exactly TIMEOUT_CYCLES cycles later, busy=0; an rx_done on the expiry cycle is accepted as the address instead.
- Send 0x04, 0x05 with cmd_ready=0, then 0x06 -> err_code=5, cmd_code/cmd_addr still 0x04/0x05; raise cmd_ready -> single transfer.
- Send 0x02, then rx_err -> err_code=4, IDLE. Separately, drop rst_n in WAIT_ADDR -> all outputs 0 immediately (asynchronously).
- With UART_CMD_CHECKSUM_EN: 0x03, 0x10, 0x13 -> cmd_valid; 0x03, 0x10, 0x00 -> err_code=6 and no cmd_valid.

Source files
------------

// File: rtl/uart_cmd_pkg.sv
// uart_cmd_pkg: shared state encoding, error codes and legal command codes
// Used by uart_cmd_decoder and by the downstream command executor.
package uart_cmd_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_ADDR = 2'd1,
        WAIT_CSUM = 2'd2,
        HOLD      = 2'd3
    } state_e;

    localparam logic [2:0] ERR_NONE     = 3'd0;
    localparam logic [2:0] ERR_BAD_CMD  = 3'd1;
    localparam logic [2:0] ERR_BAD_ADDR = 3'd2;
    localparam logic [2:0] ERR_TIMEOUT  = 3'd3;
    localparam logic [2:0] ERR_RX_ERR   = 3'd4;
    localparam logic [2:0] ERR_OVERRUN  = 3'd5;
    localparam logic [2:0] ERR_BAD_CSUM = 3'd6;

    localparam logic [7:0] CMD_NOP    = 8'h00;
    localparam logic [7:0] CMD_READ   = 8'h01;
    localparam logic [7:0] CMD_WRITE  = 8'h02;
    localparam logic [7:0] CMD_SET    = 8'h03;
    localparam logic [7:0] CMD_CLEAR  = 8'h04;
    localparam logic [7:0] CMD_TOGGLE = 8'h05;
    localparam logic [7:0] CMD_STATUS = 8'h06;
    localparam logic [7:0] CMD_RESET  = 8'h07;

endpackage

// File: rtl/uart_cmd_timer.sv
// uart_cmd_timer: saturating inter-byte timer with clear, enable and expiry flag
// Ports: clk_i, rst_ni (async active-low), clr_i (zero the count, wins over en_i),
//        en_i (count up), expired_o (count has reached TIMEOUT_CYCLES-1).
module uart_cmd_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 1600,
    parameter int unsigned CNT_W          = 11
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Holds at LAST so the count never wraps back into the legal window
    always_comb cnt_d = clr_i ? '0 : (en_i && cnt_q != LAST) ? cnt_q + 1'b1 : cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;

    assign expired_o = cnt_q == LAST;

endmodule

// File: rtl/uart_cmd_decoder.sv
// uart_cmd_decoder: assembles UART bytes into a validated command frame with handshake
// Ports: clk_i, rst_ni (async active-low); rx_data_i/rx_done_i/rx_err_i from the receiver;
//        cmd_valid_o/cmd_ready_i/cmd_code_o/cmd_addr_o frame handshake to the executor;
//        busy_o (not IDLE); err_valid_o/err_code_o one-cycle coded error pulse.
// Build option: define UART_CMD_CHECKSUM_EN for a 3-byte frame whose last byte is code^addr.
module uart_cmd_decoder
    import uart_cmd_pkg::*;
#(
    parameter logic [7:0]  MAX_CMD        = 8'h07,
    parameter int unsigned NUM_ADDR       = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1600,
    parameter int unsigned CNT_W          = 11
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [7:0] rx_data_i,
    input  logic       rx_done_i,
    input  logic       rx_err_i,
    output logic       cmd_valid_o,
    input  logic       cmd_ready_i,
    output logic [7:0] cmd_code_o,
    output logic [7:0] cmd_addr_o,
    output logic       busy_o,
    output logic       err_valid_o,
    output logic [2:0] err_code_o
);

    state_e     state_q, state_d;
    logic [2:0] err_d, err_code_q;
    logic [7:0] code_q, code_d, addr_q, addr_d;
    logic       err_valid_q, cmd_valid_q, busy_q;
    logic       ld_code, ld_addr, tmr_clr, tmr_en, expired;
    logic       byte_ok, cmd_ok, addr_ok, take_cmd;

    // A byte that arrives alongside a line error is discarded
    assign byte_ok  = rx_done_i && !rx_err_i;
    assign cmd_ok   = rx_data_i <= MAX_CMD;
    assign addr_ok  = 32'(rx_data_i) < NUM_ADDR;
    // The handshake cycle frees the frame slot, so a byte there starts a new frame
    assign take_cmd = state_q == IDLE || (state_q == HOLD && cmd_ready_i);
    assign tmr_en   = state_q == WAIT_ADDR || state_q == WAIT_CSUM;

`ifdef UART_CMD_CHECKSUM_EN
    logic csum_ok;
    assign csum_ok = rx_data_i == (code_q ^ addr_q);
`endif

    uart_cmd_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .CNT_W         (CNT_W)
    ) u_timer (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clr_i    (tmr_clr),
        .en_i     (tmr_en),
        .expired_o(expired)
    );

    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) begin
            state_q     <= IDLE;
            code_q      <= '0;
            addr_q      <= '0;
            err_code_q  <= ERR_NONE;
            err_valid_q <= 1'b0;
            cmd_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            code_q      <= code_d;
            addr_q      <= addr_d;
            err_code_q  <= err_d;
            err_valid_q <= err_d != ERR_NONE;
            cmd_valid_q <= state_d == HOLD;
            busy_q      <= state_d != IDLE;
        end

    // Error priority falls out of branch order: line error, then timeout/overrun, then content
    always_comb begin
        state_d = state_q;
        err_d   = ERR_NONE;
        ld_code = 1'b0;
        ld_addr = 1'b0;
        tmr_clr = 1'b0;
        if (rx_err_i && state_q != IDLE) begin
            state_d = IDLE;
            err_d   = ERR_RX_ERR;
        end else if (take_cmd) begin
            state_d = IDLE;
            if (byte_ok && cmd_ok) begin
                state_d = WAIT_ADDR;
                ld_code = 1'b1;
                tmr_clr = 1'b1;
            end else if (byte_ok) begin
                err_d = ERR_BAD_CMD;
            end
        end else begin
            case (state_q)
                WAIT_ADDR:
                    if (byte_ok && addr_ok) begin
                        ld_addr = 1'b1;
`ifdef UART_CMD_CHECKSUM_EN
                        state_d = WAIT_CSUM;
                        tmr_clr = 1'b1;
`else
                        state_d = HOLD;
`endif
                    end else if (byte_ok) begin
                        state_d = IDLE;
                        err_d   = ERR_BAD_ADDR;
                    end else if (expired) begin
                        state_d = IDLE;
                        err_d   = ERR_TIMEOUT;
                    end
`ifdef UART_CMD_CHECKSUM_EN
                WAIT_CSUM:
                    if (byte_ok) begin
                        state_d = csum_ok ? HOLD : IDLE;
                        err_d   = csum_ok ? ERR_NONE : ERR_BAD_CSUM;
                    end else if (expired) begin
                        state_d = IDLE;
                        err_d   = ERR_TIMEOUT;
                    end
`endif
                HOLD:
                    if (byte_ok) err_d = ERR_OVERRUN;
                default:
                    state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        code_d = ld_code ? rx_data_i : code_q;
        addr_d = ld_addr ? rx_data_i : addr_q;
    end

    assign cmd_valid_o = cmd_valid_q;
    assign cmd_code_o  = code_q;
    assign cmd_addr_o  = addr_q;
    assign busy_o      = busy_q;
    assign err_valid_o = err_valid_q;
    assign err_code_o  = err_code_q;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// tb_uart_cmd_decoder: scoreboard bench for uart_cmd_decoder frames and error pulses
module tb_uart_cmd_decoder;

    localparam int T = 1600;

    typedef struct packed {
        logic       is_err;
        logic [2:0] ec;
        logic [7:0] code;
        logic [7:0] addr;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_done = 1'b0;
    logic       rx_err = 1'b0;
    logic       cmd_ready = 1'b0;
    logic       cmd_valid, busy, err_valid;
    logic [7:0] cmd_code, cmd_addr;
    logic [2:0] err_code;

    int   checks = 0;
    int   errors = 0;
    exp_t q[$];
    exp_t e;

    always #5 clk = ~clk;

    uart_cmd_decoder #(
        .MAX_CMD(8'h07), .NUM_ADDR(32), .TIMEOUT_CYCLES(T), .CNT_W(11)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .rx_data_i(rx_data), .rx_done_i(rx_done),
        .rx_err_i(rx_err), .cmd_valid_o(cmd_valid), .cmd_ready_i(cmd_ready),
        .cmd_code_o(cmd_code), .cmd_addr_o(cmd_addr), .busy_o(busy),
        .err_valid_o(err_valid), .err_code_o(err_code)
    );

    // Scoreboard: every error pulse and every transfer must match the next expected item
    always @(negedge clk) if (rst_n) begin
        if (err_valid) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL err_unexpected got err_code %0d, expected nothing", err_code);
            end else begin
                e = q.pop_front();
                if (!e.is_err || err_code !== e.ec) begin
                    errors++;
                    $display("FAIL err_event got err_code %0d, expected is_err=%0d code %0d", err_code, e.is_err, e.ec);
                end
            end
        end
        if (cmd_valid && cmd_ready) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL frame_unexpected got %h/%h, expected nothing", cmd_code, cmd_addr);
            end else begin
                e = q.pop_front();
                if (e.is_err || cmd_code !== e.code || cmd_addr !== e.addr) begin
                    errors++;
                    $display("FAIL frame_event got %h/%h, expected is_err=%0d %h/%h", cmd_code, cmd_addr, e.is_err, e.code, e.addr);
                end
            end
        end
        checks++;
        if (!err_valid && err_code !== 3'd0) begin
            errors++;
            $display("FAIL err_code_idle got %0d, expected 0", err_code);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic exp_err(input logic [2:0] ec);
        q.push_back('{1'b1, ec, 8'h00, 8'h00});
    endtask

    task automatic exp_frame(input logic [7:0] c, input logic [7:0] a);
        q.push_back('{1'b0, 3'd0, c, a});
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx_data = b;
        rx_done = 1'b1;
        @(posedge clk); #1;
        rx_done = 1'b0;
    endtask

    task automatic finish_frame(input logic [7:0] c, input logic [7:0] a);
`ifdef UART_CMD_CHECKSUM_EN
        send_byte(c ^ a);
`endif
    endtask

    task automatic test_reset;
        #3 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({cmd_valid, busy, err_valid} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags got %b, expected 000", {cmd_valid, busy, err_valid});
        end
        checks++;
        if ({cmd_code, cmd_addr, err_code} !== 19'd0) begin
            errors++;
            $display("FAIL reset_data got %h/%h/%0d, expected 0", cmd_code, cmd_addr, err_code);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic;
        cmd_ready = 1'b1;
        exp_frame(8'h03, 8'h10);
        send_byte(8'h03);
        checks++;
        if (busy !== 1'b1 || cmd_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_after_code got busy %b valid %b, expected 1 0", busy, cmd_valid);
        end
        send_byte(8'h10);
        finish_frame(8'h03, 8'h10);
        checks++;
        if (cmd_valid !== 1'b1 || cmd_code !== 8'h03 || cmd_addr !== 8'h10) begin
            errors++;
            $display("FAIL basic_valid got %b %h/%h, expected 1 03/10", cmd_valid, cmd_code, cmd_addr);
        end
        @(posedge clk); #1;
        checks++;
        if (cmd_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_done got valid %b busy %b, expected 0 0", cmd_valid, busy);
        end
    endtask

    task automatic test_bad_cmd;
        exp_err(3'd1);
        send_byte(8'h09);
        checks++;
        if (err_valid !== 1'b1 || err_code !== 3'd1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL bad_cmd got ev %b code %0d busy %b, expected 1 1 0", err_valid, err_code, busy);
        end
        @(posedge clk); #1;
        checks++;
        if (err_valid !== 1'b0) begin
            errors++;
            $display("FAIL bad_cmd_pulse got %b, expected 0", err_valid);
        end
        exp_err(3'd1);
        send_byte(8'h08);
        exp_frame(8'h01, 8'h02);
        send_byte(8'h01);
        send_byte(8'h02);
        finish_frame(8'h01, 8'h02);
        exp_err(3'd2);
        send_byte(8'h07);
        send_byte(8'h20);
        checks++;
        if (err_code !== 3'd2 || busy !== 1'b0) begin
            errors++;
            $display("FAIL bad_addr got code %0d busy %b, expected 2 0", err_code, busy);
        end
        exp_frame(8'h07, 8'h1f);
        send_byte(8'h07);
        send_byte(8'h1f);
        finish_frame(8'h07, 8'h1f);
        checks++;
        if (cmd_valid !== 1'b1 || cmd_addr !== 8'h1f) begin
            errors++;
            $display("FAIL max_addr got %b %h, expected 1 1f", cmd_valid, cmd_addr);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_timeout;
        exp_err(3'd3);
        send_byte(8'h01);
        repeat (T - 1) @(posedge clk);
        #1;
        checks++;
        if (err_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL timeout_early got ev %b busy %b, expected 0 1", err_valid, busy);
        end
        @(posedge clk); #1;
        checks++;
        if (err_valid !== 1'b1 || err_code !== 3'd3 || busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout got ev %b code %0d busy %b, expected 1 3 0", err_valid, err_code, busy);
        end
        exp_frame(8'h01, 8'h05);
        send_byte(8'h01);
        repeat (T - 2) @(posedge clk);
        send_byte(8'h05);
        checks++;
        if (err_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL timeout_edge_byte got ev %b busy %b, expected 0 1", err_valid, busy);
        end
        finish_frame(8'h01, 8'h05);
        checks++;
        if (cmd_valid !== 1'b1 || cmd_addr !== 8'h05) begin
            errors++;
            $display("FAIL timeout_edge_frame got %b %h, expected 1 05", cmd_valid, cmd_addr);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_overrun;
        cmd_ready = 1'b0;
        send_byte(8'h04);
        send_byte(8'h05);
        finish_frame(8'h04, 8'h05);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (cmd_valid !== 1'b1) begin
            errors++;
            $display("FAIL overrun_hold got %b, expected 1", cmd_valid);
        end
        exp_err(3'd5);
        send_byte(8'h06);
        checks++;
        if (err_code !== 3'd5 || cmd_valid !== 1'b1 || cmd_code !== 8'h04 || cmd_addr !== 8'h05) begin
            errors++;
            $display("FAIL overrun got code %0d valid %b %h/%h, expected 5 1 04/05", err_code, cmd_valid, cmd_code, cmd_addr);
        end
        exp_frame(8'h04, 8'h05);
        cmd_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (cmd_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL overrun_xfer got valid %b busy %b, expected 0 0", cmd_valid, busy);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back;
        cmd_ready = 1'b0;
        send_byte(8'h02);
        send_byte(8'h03);
        finish_frame(8'h02, 8'h03);
        exp_frame(8'h02, 8'h03);
        exp_frame(8'h05, 8'h07);
        @(posedge clk); #1;
        rx_data = 8'h05;
        rx_done = 1'b1;
        cmd_ready = 1'b1;
        @(posedge clk); #1;
        rx_done = 1'b0;
        checks++;
        if (cmd_valid !== 1'b0 || busy !== 1'b1 || cmd_code !== 8'h05) begin
            errors++;
            $display("FAIL b2b_new got valid %b busy %b code %h, expected 0 1 05", cmd_valid, busy, cmd_code);
        end
        send_byte(8'h07);
        finish_frame(8'h05, 8'h07);
        checks++;
        if (cmd_valid !== 1'b1 || cmd_addr !== 8'h07) begin
            errors++;
            $display("FAIL b2b_frame got %b %h, expected 1 07", cmd_valid, cmd_addr);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_rx_err;
        cmd_ready = 1'b1;
        send_byte(8'h02);
        exp_err(3'd4);
        @(posedge clk); #1 rx_err = 1'b1;
        @(posedge clk); #1 rx_err = 1'b0;
        checks++;
        if (err_code !== 3'd4 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rx_err got code %0d busy %b, expected 4 0", err_code, busy);
        end
        @(posedge clk); #1 rx_err = 1'b1;
        @(posedge clk); #1 rx_err = 1'b0;
        checks++;
        if (err_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rx_err_idle got ev %b busy %b, expected 0 0", err_valid, busy);
        end
        send_byte(8'h02);
        exp_err(3'd4);
        @(posedge clk); #1;
        rx_err = 1'b1;
        rx_done = 1'b1;
        rx_data = 8'h05;
        @(posedge clk); #1;
        rx_err = 1'b0;
        rx_done = 1'b0;
        checks++;
        if (err_code !== 3'd4 || cmd_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rx_err_byte got code %0d valid %b busy %b, expected 4 0 0", err_code, cmd_valid, busy);
        end
        cmd_ready = 1'b0;
        send_byte(8'h01);
        send_byte(8'h02);
        finish_frame(8'h01, 8'h02);
        exp_err(3'd4);
        @(posedge clk); #1 rx_err = 1'b1;
        @(posedge clk); #1 rx_err = 1'b0;
        checks++;
        if (err_code !== 3'd4 || cmd_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rx_err_hold got code %0d valid %b busy %b, expected 4 0 0", err_code, cmd_valid, busy);
        end
        cmd_ready = 1'b1;
    endtask

    task automatic test_async_reset;
        send_byte(8'h02);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({cmd_valid, busy, err_valid} !== 3'b000 || {cmd_code, cmd_addr, err_code} !== 19'd0) begin
            errors++;
            $display("FAIL async_reset got %b %h/%h/%0d, expected all 0", {cmd_valid, busy, err_valid}, cmd_code, cmd_addr, err_code);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        exp_frame(8'h06, 8'h00);
        send_byte(8'h06);
        send_byte(8'h00);
        finish_frame(8'h06, 8'h00);
        @(posedge clk); #1;
    endtask

`ifdef UART_CMD_CHECKSUM_EN
    task automatic test_checksum;
        cmd_ready = 1'b1;
        exp_frame(8'h03, 8'h10);
        send_byte(8'h03);
        send_byte(8'h10);
        send_byte(8'h13);
        checks++;
        if (cmd_valid !== 1'b1) begin
            errors++;
            $display("FAIL csum_good got %b, expected 1", cmd_valid);
        end
        @(posedge clk); #1;
        exp_err(3'd6);
        send_byte(8'h03);
        send_byte(8'h10);
        send_byte(8'h00);
        checks++;
        if (err_code !== 3'd6 || cmd_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL csum_bad got code %0d valid %b busy %b, expected 6 0 0", err_code, cmd_valid, busy);
        end
        @(posedge clk); #1;
    endtask
`endif

    initial begin
        test_reset;
        test_basic;
        test_bad_cmd;
        test_timeout;
        test_overrun;
        test_back_to_back;
        test_rx_err;
        test_async_reset;
`ifdef UART_CMD_CHECKSUM_EN
        test_checksum;
`endif
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending, expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
